// File: rtl/cc_or_row_scheduler.sv
// -----------------------------------------------------------------------------
// cc_or_row_scheduler
//
// Frame sequencer for the obstacle/point OR compositing path of the LED-matrix
// game. A frame starts when the active-low start request is seen in IDLE. The
// block then walks rows 0..NUMBER_ROWS-1. For each row it reads the obstacle
// row and the point row, ORs them, and pushes the result to the display driver
// over a valid/ready handshake. It also reports whether any bit was set in
// both the obstacle and the point row at any point during the frame.
//
// Ports
//   CC_ORSCHED_CLOCK_50       in   system clock, rising edge
//   CC_ORSCHED_RESET_InHigh   in   asynchronous active-high reset
//   CC_ORSCHED_start_InLow    in   frame start request (0 = start), IDLE only
//   CC_ORSCHED_rdAddr_OutBUS  out  row address to both row sources
//   CC_ORSCHED_rdEn_Out       out  read strobe; data arrive the next cycle
//   CC_ORSCHED_obs_InBUS      in   obstacle row data
//   CC_ORSCHED_point_InBUS    in   point (player) row data
//   CC_ORSCHED_OutBUS         out  composited row (obs | point)
//   CC_ORSCHED_row_OutBUS     out  row index belonging to OutBUS
//   CC_ORSCHED_valid_Out      out  OutBUS/row_OutBUS valid
//   CC_ORSCHED_ready_In       in   display driver accepts the row
//   CC_ORSCHED_busy_Out       out  high whenever not IDLE
//   CC_ORSCHED_frameDone_Out  out  one-cycle pulse at frame end
//   CC_ORSCHED_collision_Out  out  collision result of the last finished frame
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start request; row counter and accumulator reset on start
// FETCH | rdEn asserted with rdAddr = row counter (one cycle)
// WAIT  | source data valid; capture OR result, row index, collision bit
// PUSH  | valid asserted until the display driver takes the row
// DONE  | frameDone pulse; collision output takes the frame accumulator
// -----------------------------------------------------------------------------
module cc_or_row_scheduler #(
    parameter int NUMBER_DATAWIDTH = 8,
    parameter int NUMBER_ROWS      = 8,
    parameter int NUMBER_ROWADDR   = 3
) (
    input  logic                        CC_ORSCHED_CLOCK_50,
    input  logic                        CC_ORSCHED_RESET_InHigh,
    input  logic                        CC_ORSCHED_start_InLow,
    output logic [NUMBER_ROWADDR-1:0]   CC_ORSCHED_rdAddr_OutBUS,
    output logic                        CC_ORSCHED_rdEn_Out,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_ORSCHED_obs_InBUS,
    input  logic [NUMBER_DATAWIDTH-1:0] CC_ORSCHED_point_InBUS,
    output logic [NUMBER_DATAWIDTH-1:0] CC_ORSCHED_OutBUS,
    output logic [NUMBER_ROWADDR-1:0]   CC_ORSCHED_row_OutBUS,
    output logic                        CC_ORSCHED_valid_Out,
    input  logic                        CC_ORSCHED_ready_In,
    output logic                        CC_ORSCHED_busy_Out,
    output logic                        CC_ORSCHED_frameDone_Out,
    output logic                        CC_ORSCHED_collision_Out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PUSH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [NUMBER_ROWADDR-1:0] LAST_ROW = NUMBER_ROWADDR'(NUMBER_ROWS - 1);
    localparam logic [NUMBER_ROWADDR-1:0] ROW_ONE  = NUMBER_ROWADDR'(1);

    state_t                        state_q, state_d;
    logic [NUMBER_ROWADDR-1:0]     row_q, row_d;
    logic [NUMBER_DATAWIDTH-1:0]   out_q, out_d;
    logic [NUMBER_ROWADDR-1:0]     out_row_q, out_row_d;
    logic                          acc_q, acc_d;
    logic                          coll_q, coll_d;

    always_ff @(posedge CC_ORSCHED_CLOCK_50 or posedge CC_ORSCHED_RESET_InHigh) begin
        if (CC_ORSCHED_RESET_InHigh) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            out_q     <= '0;
            out_row_q <= '0;
            acc_q     <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            out_q     <= out_d;
            out_row_q <= out_row_d;
            acc_q     <= acc_d;
            coll_q    <= coll_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        out_d     = out_q;
        out_row_d = out_row_q;
        acc_d     = acc_q;
        coll_d    = coll_q;

        case (state_q)
            ST_IDLE: begin
                if (!CC_ORSCHED_start_InLow) begin
                    state_d = ST_FETCH;
                    row_d   = '0;
                    acc_d   = 1'b0;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                out_d     = CC_ORSCHED_obs_InBUS | CC_ORSCHED_point_InBUS;
                out_row_d = row_q;
                acc_d     = acc_q | (|(CC_ORSCHED_obs_InBUS & CC_ORSCHED_point_InBUS));
                state_d   = ST_PUSH;
            end
            ST_PUSH: begin
                // Output registers are untouched here, so a stall keeps the
                // row stable for as long as ready stays low.
                if (CC_ORSCHED_ready_In) begin
                    if (row_q == LAST_ROW) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + ROW_ONE;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                coll_d  = acc_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The row counter only changes on start or on a handshake, so it doubles
    // as the read address and naturally holds between fetches.
    assign CC_ORSCHED_rdAddr_OutBUS = row_q;
    assign CC_ORSCHED_rdEn_Out      = (state_q == ST_FETCH);
    assign CC_ORSCHED_OutBUS        = out_q;
    assign CC_ORSCHED_row_OutBUS    = out_row_q;
    assign CC_ORSCHED_valid_Out     = (state_q == ST_PUSH);
    assign CC_ORSCHED_busy_Out      = (state_q != ST_IDLE);
    assign CC_ORSCHED_frameDone_Out = (state_q == ST_DONE);
    assign CC_ORSCHED_collision_Out = coll_q;

endmodule

// File: tb/tb_cc_or_row_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cc_or_row_scheduler
//
// Bench for cc_or_row_scheduler. A row-source model answers each read strobe
// with pattern data one cycle later (random data at all other times) and pushes
// the expected composited row onto a scoreboard; every handshake pops it.
// -----------------------------------------------------------------------------
module tb_cc_or_row_scheduler;

    localparam int W = 8;
    localparam int N = 8;
    localparam int A = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_n = 1'b1;
    logic          ready = 1'b1;
    logic [A-1:0]  rd_addr;
    logic          rd_en;
    logic [W-1:0]  obs;
    logic [W-1:0]  pt;
    logic [W-1:0]  out;
    logic [A-1:0]  row;
    logic          valid;
    logic          busy;
    logic          done;
    logic          coll;

    cc_or_row_scheduler #(
        .NUMBER_DATAWIDTH (W),
        .NUMBER_ROWS      (N),
        .NUMBER_ROWADDR   (A)
    ) dut (
        .CC_ORSCHED_CLOCK_50      (clk),
        .CC_ORSCHED_RESET_InHigh  (rst),
        .CC_ORSCHED_start_InLow   (start_n),
        .CC_ORSCHED_rdAddr_OutBUS (rd_addr),
        .CC_ORSCHED_rdEn_Out      (rd_en),
        .CC_ORSCHED_obs_InBUS     (obs),
        .CC_ORSCHED_point_InBUS   (pt),
        .CC_ORSCHED_OutBUS        (out),
        .CC_ORSCHED_row_OutBUS    (row),
        .CC_ORSCHED_valid_Out     (valid),
        .CC_ORSCHED_ready_In      (ready),
        .CC_ORSCHED_busy_Out      (busy),
        .CC_ORSCHED_frameDone_Out (done),
        .CC_ORSCHED_collision_Out (coll)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: obs = 1<<row, point = 8'h80 ; mode 1: obs = 8'h0F, point = 8'hF0
    int mode = 0;

    function automatic logic [W-1:0] obs_pat(input int m, input int r);
        logic [W-1:0] one;
        one = W'(1);
        return (m == 0) ? (one << r) : W'(8'h0F);
    endfunction

    function automatic logic [W-1:0] pt_pat(input int m);
        return (m == 0) ? W'(8'h80) : W'(8'hF0);
    endfunction

    int           fetch_idx = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    int           hs_cnt = 0;
    int           rden_cnt = 0;
    int           fetch_cyc = 0;
    int           done_cyc = 0;
    bit           pend = 1'b0;
    logic [W-1:0] n_obs;
    logic [W-1:0] n_pt;
    logic [W-1:0] q_data[$];
    int           q_row[$];

    // Row sources: data valid only in the cycle after the read strobe.
    always @(posedge clk) begin
        cyc++;
        if (pend) begin
            obs  <= n_obs;
            pt   <= n_pt;
            pend = 1'b0;
        end else begin
            obs <= W'($urandom);
            pt  <= W'($urandom);
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rd_en) begin
            rden_cnt++;
            chk_eq("rd_addr", 32'(rd_addr), 32'(fetch_idx));
            if (fetch_idx == 0) fetch_cyc = cyc;
            n_obs = obs_pat(mode, fetch_idx);
            n_pt  = pt_pat(mode);
            q_data.push_back(n_obs | n_pt);
            q_row.push_back(fetch_idx);
            pend = 1'b1;
            fetch_idx++;
        end
        if (valid && ready) begin
            hs_cnt++;
            if (q_data.size() == 0) begin
                chk_eq("sb_empty", 32'(q_data.size()), 32'd1);
            end else begin
                chk_eq("out_data", 32'(out), 32'(q_data.pop_front()));
                chk_eq("out_row", 32'(row), 32'(q_row.pop_front()));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic start_frame();
        fetch_idx = 0;
        @(posedge clk);
        #1 start_n = 1'b0;
        @(posedge clk);
        #1 start_n = 1'b1;
    endtask

    task automatic wait_fetch(input int r);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rd_en && (32'(rd_addr) == r)) begin
                hit = 1'b1;
                break;
            end
        end
        chk_eq("fetch_seen", 32'(hit), 32'd1);
    endtask

    // Returns one cycle after DONE, with the collision output updated.
    task automatic wait_done();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done) begin
                hit = 1'b1;
                break;
            end
        end
        chk_eq("done_seen", 32'(hit), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_rden"}, 32'(rd_en), 32'd0);
        chk_eq({tag, "_rdaddr"}, 32'(rd_addr), 32'd0);
        chk_eq({tag, "_out"}, 32'(out), 32'd0);
        chk_eq({tag, "_row"}, 32'(row), 32'd0);
        chk_eq({tag, "_valid"}, 32'(valid), 32'd0);
        chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
        chk_eq({tag, "_done"}, 32'(done), 32'd0);
        chk_eq({tag, "_coll"}, 32'(coll), 32'd0);
    endtask

    int hs0;
    int d0;
    int r0;

    initial begin
        // 1: reset, then idle with no start
        #2 chk_all_zero("rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        r0 = rden_cnt;
        repeat (20) @(negedge clk);
        chk_eq("idle_rden_cnt", 32'(rden_cnt - r0), 32'd0);
        chk_all_zero("idle");

        // 2: full frame, ready high, collision on row 7
        mode = 0;
        hs0 = hs_cnt;
        start_frame();
        wait_done();
        chk_eq("f2_rows", 32'(hs_cnt - hs0), 32'd8);
        chk_eq("f2_latency", 32'(done_cyc - fetch_cyc), 32'd24);
        chk_eq("f2_coll", 32'(coll), 32'd1);
        chk_eq("f2_busy", 32'(busy), 32'd0);
        chk_eq("f2_sb_left", 32'(q_data.size()), 32'd0);

        // 3: disjoint rows, all outputs 8'hFF, no collision
        mode = 1;
        hs0 = hs_cnt;
        start_frame();
        wait_done();
        chk_eq("f3_rows", 32'(hs_cnt - hs0), 32'd8);
        chk_eq("f3_coll", 32'(coll), 32'd0);

        // 4: backpressure on row 3
        mode = 0;
        hs0 = hs_cnt;
        start_frame();
        wait_fetch(3);
        @(posedge clk);
        #1 ready = 1'b0;
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            chk_eq("bp_valid", 32'(valid), 32'd1);
            chk_eq("bp_out", 32'(out), 32'h88);
            chk_eq("bp_row", 32'(row), 32'd3);
            chk_eq("bp_rden", 32'(rd_en), 32'd0);
            @(posedge clk);
        end
        #1 ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_eq("bp_next_rden", 32'(rd_en), 32'd1);
        chk_eq("bp_next_addr", 32'(rd_addr), 32'd4);
        wait_done();
        chk_eq("f4_rows", 32'(hs_cnt - hs0), 32'd8);
        chk_eq("f4_coll", 32'(coll), 32'd1);

        // 5: start during row 2 PUSH is ignored
        hs0 = hs_cnt;
        d0 = done_cnt;
        r0 = rden_cnt;
        start_frame();
        wait_fetch(2);
        @(posedge clk);
        @(posedge clk);
        #1 start_n = 1'b0;
        @(posedge clk);
        #1 start_n = 1'b1;
        wait_done();
        repeat (20) @(negedge clk);
        chk_eq("f5_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk_eq("f5_rden_cnt", 32'(rden_cnt - r0), 32'd8);
        chk_eq("f5_rows", 32'(hs_cnt - hs0), 32'd8);
        chk_eq("f5_busy", 32'(busy), 32'd0);
        chk_eq("f5_coll", 32'(coll), 32'd1);

        // 6: reset during row 5 WAIT, then a clean frame
        start_frame();
        wait_fetch(5);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_all_zero("midrst");
        q_data.delete();
        q_row.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk_eq("f6_no_done", 32'(done_cnt - d0), 32'd0);
        chk_eq("f6_idle_busy", 32'(busy), 32'd0);
        hs0 = hs_cnt;
        start_frame();
        wait_done();
        chk_eq("f6_rows", 32'(hs_cnt - hs0), 32'd8);
        chk_eq("f6_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk_eq("f6_coll", 32'(coll), 32'd1);
        chk_eq("f6_sb_left", 32'(q_data.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_or_row_scheduler.md
Name: cc_or_row_scheduler

Overview:
Frame sequencer for the obstacle/point OR compositing path of the LED-matrix game. On each frame start it walks rows 0..NUM_ROWS-1. For each row it:
- reads the obstacle row and the point (player) row from their row sources;
- forms their bitwise OR;
- pushes the result to the matrix display driver over a valid/ready handshake.
It also reports a per-frame collision flag: any bit set in both obstacle and point rows.

Parameters:
NUMBER_DATAWIDTH, 8, width of one matrix row (obstacle, point and output buses)
NUMBER_ROWS, 8, rows per frame; must be ≥2
NUMBER_ROWADDR, 3, row address width; must satisfy 2^NUMBER_ROWADDR ≥ NUMBER_ROWS

Ports:
CC_ORSCHED_CLOCK_50  input  1  system clock; all logic on rising edge
CC_ORSCHED_RESET_InHigh  input  1  asynchronous, active-high reset
CC_ORSCHED_start_InLow  input  1  frame start request, active-low (0 = start); sampled only in IDLE
CC_ORSCHED_rdAddr_OutBUS  output  NUMBER_ROWADDR  row address to obstacle and point sources
CC_ORSCHED_rdEn_Out  output  1  read strobe to both sources
CC_ORSCHED_obs_InBUS  input  NUMBER_DATAWIDTH  obstacle row data; valid the cycle after rdEn
CC_ORSCHED_point_InBUS  input  NUMBER_DATAWIDTH  point row data; valid the cycle after rdEn
CC_ORSCHED_OutBUS  output  NUMBER_DATAWIDTH  composited row (obs | point)
CC_ORSCHED_row_OutBUS  output  NUMBER_ROWADDR  row index of CC_ORSCHED_OutBUS
CC_ORSCHED_valid_Out  output  1  OutBUS/row_OutBUS valid
CC_ORSCHED_ready_In  input  1  display driver accepts the row
CC_ORSCHED_busy_Out  output  1  high in every state except IDLE
CC_ORSCHED_frameDone_Out  output  1  one-cycle pulse at frame end
CC_ORSCHED_collision_Out  output  1  collision result of the last completed frame

Behaviour:
- Reset (async, active-high, immediate):
  - state = IDLE; row counter = 0; accumulator = 0.
  - All outputs 0: rdAddr, rdEn, OutBUS, row_OutBUS, valid, busy, frameDone, collision.
  - Reset mid-frame abandons the frame with no frameDone. Collision returns to 0.
- States: IDLE, FETCH, WAIT, PUSH, DONE.
- IDLE:
  - start_InLow = 0 at a rising edge → FETCH; row counter = 0; collision accumulator cleared.
  - Otherwise stay in IDLE.
- FETCH (1 cycle):
  - rdEn = 1, rdAddr = row counter → WAIT.
  - rdEn is 0 in all other states. rdAddr holds its last value.
- WAIT (1 cycle):
  - Source data are valid on obs/point inputs.
  - At the end of the cycle, register OutBUS = obs | point and row_OutBUS = row counter.
  - Accumulator |= (|(obs & point)) → PUSH.
- PUSH:
  - valid = 1; OutBUS and row_OutBUS held stable until the handshake.
  - Handshake occurs at the edge where valid & ready = 1.
  - On handshake: if row counter == NUMBER_ROWS-1 → DONE; else row counter + 1 → FETCH.
  - valid drops in the cycle after the handshake.
  - ready = 0 stalls indefinitely with no data change.
  - ready while not in PUSH is ignored.
- DONE (1 cycle):
  - frameDone = 1; collision ← accumulator; → IDLE.
  - collision holds until the next DONE or reset.
- Start handling: start in any state other than IDLE is ignored, with no queuing. Start held low continuously launches back-to-back frames, one IDLE cycle between frames.
- Latency (ready tied to 1):
  - start sampled at edge k; FETCH in cycle k+1; first valid in cycle k+3.
  - 3 cycles per row; frameDone in cycle k+3·NUMBER_ROWS+1.
  - busy high from k+1 through DONE.
- Row counter never exceeds NUMBER_ROWS-1; no wrap-around within a frame.
- The OR is purely bitwise, NUMBER_DATAWIDTH bits, with no carry or truncation.

Test Plan:
1. Reset then idle (start_InLow=1, 20 cycles) → all outputs 0, rdEn never asserts.
2. Full frame, ready=1: obstacle row r = 8'h01<<r, point = 8'h80 on all rows; start pulse (start_InLow=0 for one cycle) → 8 rows out: 8'h81, 8'h82, …, 8'hC0, 8'h80, rows 0..7 in order. frameDone exactly 24 cycles after FETCH entry. collision=1, from row 7 (obs 8'h80 & point 8'h80).
3. No overlap: obstacle 8'h0F, point 8'hF0 all rows → every OutBUS = 8'hFF; collision=0 after frameDone.
4. Backpressure: ready=0 for 5 cycles on row 3 → valid held, OutBUS/row_OutBUS = 3 unchanged, no rdEn. Row 4 fetch starts the cycle after ready rises.
5. Ignored start: start_InLow=0 during row 2 PUSH → no restart; the single frame completes; exactly one frameDone.
6. Reset mid-frame during row 5 WAIT → outputs 0 immediately, no frameDone, previous collision=1 cleared. A new start then runs a full 8-row frame from row 0.
